// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: FWFT byte FIFO, error statistics and
// automatic receiver resync after repeated bad frames.
module uart_rx_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned HOLD_CYC = 32,
  parameter int unsigned IDLE_CYC = 160
) (
  input  logic             ctl_clk,
  input  logic             ctl_rst,
  input  logic [WIDTH-1:0] rx_byte,
  input  logic             rx_done,
  input  logic             rx_fail,
  input  logic             rx_line,
  output logic             rx_hold,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_stat,
  output logic [7:0]       err_cnt,
  output logic [3:0]       resync_cnt,
  output logic             ovf,
  output logic [1:0]       state_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam int unsigned IW = $clog2(IDLE_CYC + 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [FW-1:0]    fail_run_q, fail_run_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [3:0]       resync_q, resync_d;
  logic             ovf_q, ovf_d;
  logic             pop, push_req, push_ok;

  always_ff @(posedge ctl_clk or posedge ctl_rst) begin
    if (ctl_rst) begin
      state_q    <= RUN;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fail_run_q <= '0;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
      err_cnt_q  <= '0;
      resync_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fail_run_q <= fail_run_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_cnt_q  <= err_cnt_d;
      resync_q   <= resync_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fail_run_d = fail_run_q;
    hold_cnt_d = hold_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_cnt_d  = err_cnt_q;
    resync_d   = resync_q;
    ovf_d      = ovf_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    pop      = (count_q != '0) && out_ready;
    push_req = (state_q == RUN) && rx_done && !rx_fail;
    push_ok  = push_req && ((count_q != CW'(DEPTH)) || pop);

    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_byte;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    if (push_req && !push_ok) ovf_d = 1'b1;

    unique case (state_q)
      RUN: begin
        if (rx_done && rx_fail) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          fail_run_d = fail_run_q + FW'(1);
          if (fail_run_q == FW'(MAX_FAIL - 1)) begin
            state_d    = HOLD;
            hold_cnt_d = HW'(HOLD_CYC - 1);
          end
        end else if (rx_done) begin
          fail_run_d = '0;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d    = WAIT_IDLE;
          idle_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      WAIT_IDLE: begin
        if (!rx_line) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(IDLE_CYC - 1)) begin
          state_d    = RUN;
          idle_cnt_d = '0;
          fail_run_d = '0;
          if (resync_q != 4'hF) resync_d = resync_q + 4'd1;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (clr_stat) begin
      err_cnt_d = '0;
      resync_d  = '0;
      ovf_d     = 1'b0;
    end
  end

  always_comb begin
    rx_hold    = (state_q != RUN);
    state_o    = state_q;
    out_valid  = (count_q != '0);
    out_data   = mem_q[rd_ptr_q];
    err_cnt    = err_cnt_q;
    resync_cnt = resync_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8, MAX_FAIL = 3, HOLD_CYC = 32, IDLE_CYC = 160;

  logic       ctl_clk = 1'b0, ctl_rst = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       rx_done = 1'b0, rx_fail = 1'b0, rx_line = 1'b1;
  logic       out_ready = 1'b0, clr_stat = 1'b0;
  logic       rx_hold, out_valid, ovf;
  logic [7:0] out_data, err_cnt;
  logic [3:0] resync_cnt;
  logic [1:0] state_o;

  int n_chk = 0, n_fail = 0;

  uart_rx_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .MAX_FAIL(MAX_FAIL),
                 .HOLD_CYC(HOLD_CYC), .IDLE_CYC(IDLE_CYC)) dut (
    .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .rx_byte(rx_byte), .rx_done(rx_done),
    .rx_fail(rx_fail), .rx_line(rx_line), .rx_hold(rx_hold), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .clr_stat(clr_stat),
    .err_cnt(err_cnt), .resync_cnt(resync_cnt), .ovf(ovf), .state_o(state_o));

  always #5 ctl_clk = ~ctl_clk;

  // Reference model: queue FIFO, integer counters, mode 0/1/2.
  logic [7:0] q[$];
  int m_state = 0, m_err = 0, m_resync = 0, m_fail_run = 0;
  int m_hold_left = 0, m_idle_run = 0;
  bit m_ovf = 0;

  always @(posedge ctl_clk or posedge ctl_rst) begin
    if (ctl_rst) begin
      q.delete();
      m_state = 0; m_err = 0; m_resync = 0; m_fail_run = 0;
      m_hold_left = 0; m_idle_run = 0; m_ovf = 0;
    end else begin
      bit pop, push;
      int size_before;
      size_before = q.size();
      pop  = (size_before > 0) && out_ready;
      push = (m_state == 0) && rx_done && !rx_fail;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (size_before < DEPTH || pop) q.push_back(rx_byte);
        else m_ovf = 1;
      end
      case (m_state)
        0: if (rx_done && rx_fail) begin
             if (m_err < 255) m_err++;
             m_fail_run++;
             if (m_fail_run == MAX_FAIL) begin m_state = 1; m_hold_left = HOLD_CYC; end
           end else if (rx_done) m_fail_run = 0;
        1: begin
             m_hold_left--;
             if (m_hold_left == 0) begin m_state = 2; m_idle_run = 0; end
           end
        default: begin
             m_idle_run = rx_line ? m_idle_run + 1 : 0;
             if (m_idle_run == IDLE_CYC) begin
               m_state = 0; m_fail_run = 0;
               if (m_resync < 15) m_resync++;
             end
           end
      endcase
      if (clr_stat) begin m_err = 0; m_resync = 0; m_ovf = 0; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ctl_clk) begin
    chk("model out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("model out_data", 32'(out_data), 32'(q[0]));
    chk("model rx_hold", 32'(rx_hold), 32'(m_state != 0));
    chk("model state_o", 32'(state_o), 32'(m_state));
    chk("model err_cnt", 32'(err_cnt), 32'(m_err));
    chk("model resync_cnt", 32'(resync_cnt), 32'(m_resync));
    chk("model ovf", 32'(ovf), 32'(m_ovf));
  end

  task automatic step();
    @(posedge ctl_clk);
    #2;
  endtask

  task automatic frame(input logic [7:0] b, input logic bad);
    rx_done = 1'b1; rx_fail = bad; rx_byte = b;
    step();
    rx_done = 1'b0; rx_fail = 1'b0;
  endtask

  logic [7:0] drain_exp [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
  logic [7:0] good3 [3] = '{8'h34, 8'hA8, 8'hB4};

  initial begin
    #1;
    chk("reset rx_hold", 32'(rx_hold), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset err_cnt", 32'(err_cnt), 0);
    chk("reset resync_cnt", 32'(resync_cnt), 0);
    chk("reset ovf", 32'(ovf), 0);
    chk("reset state", 32'(state_o), 0);
    repeat (2) step();
    ctl_rst = 1'b0;
    step();

    // Three good frames, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame(good3[i], 1'b0);
      chk("good head valid", 32'(out_valid), 1);
      chk("good head data", 32'(out_data), 32'(good3[i]));
      step();
      chk("good popped", 32'(out_valid), 0);
    end
    chk("good err_cnt", 32'(err_cnt), 0);
    chk("good state", 32'(state_o), 0);

    // Overflow: nine pushes into an 8-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      frame(8'(b), 1'b0);
      chk("fill valid", 32'(out_valid), 1);
    end
    chk("ovf set", 32'(ovf), 1);
    chk("ovf head", 32'(out_data), 8'h01);
    clr_stat = 1'b1; step(); clr_stat = 1'b0;
    chk("ovf cleared", 32'(ovf), 0);

    // Push and pop together while full
    out_ready = 1'b1;
    frame(8'h0A, 1'b0);
    chk("full push+pop ovf", 32'(ovf), 0);
    chk("full push+pop head", 32'(out_data), 8'h02);
    for (int i = 0; i < 8; i++) begin
      chk("drain data", 32'(out_data), 32'(drain_exp[i]));
      step();
    end
    chk("drained empty", 32'(out_valid), 0);

    // Fail, fail, good, fail: no resync
    clr_stat = 1'b1; step(); clr_stat = 1'b0;
    frame(8'h00, 1'b1); step();
    frame(8'h00, 1'b1); step();
    frame(8'h55, 1'b0); step();
    frame(8'h00, 1'b1); step();
    chk("ffgf err_cnt", 32'(err_cnt), 3);
    chk("ffgf state", 32'(state_o), 0);
    chk("ffgf resync", 32'(resync_cnt), 0);

    // Three consecutive fails -> HOLD -> WAIT_IDLE -> RUN
    frame(8'h66, 1'b0); step();
    frame(8'h00, 1'b1);
    frame(8'h00, 1'b1);
    frame(8'h00, 1'b1);
    chk("hold asserted", 32'(rx_hold), 1);
    chk("hold state", 32'(state_o), 1);
    rx_line = 1'b0;
    for (int i = 0; i < HOLD_CYC - 1; i++) begin
      if (i == 5) frame(8'hEE, 1'b0);
      else if (i == 10) frame(8'h00, 1'b1);
      else step();
    end
    chk("hold still", 32'(state_o), 1);
    chk("hold ignores rx_done valid", 32'(out_valid), 0);
    chk("hold ignores rx_done err", 32'(err_cnt), 6);
    step();
    chk("wait state", 32'(state_o), 2);
    repeat (100) step();
    rx_line = 1'b1;
    repeat (IDLE_CYC - 1) step();
    chk("wait not yet done", 32'(state_o), 2);
    chk("wait hold", 32'(rx_hold), 1);
    step();
    chk("resync state", 32'(state_o), 0);
    chk("resync rx_hold", 32'(rx_hold), 0);
    chk("resync count", 32'(resync_cnt), 1);

    // Clear collides with a failing frame
    clr_stat = 1'b1; step(); clr_stat = 1'b0;
    frame(8'h00, 1'b1); frame(8'h00, 1'b1); frame(8'h11, 1'b0);
    frame(8'h00, 1'b1); frame(8'h00, 1'b1); frame(8'h22, 1'b0);
    frame(8'h00, 1'b1);
    chk("pre-clear err_cnt", 32'(err_cnt), 5);
    clr_stat = 1'b1;
    frame(8'h00, 1'b1);
    clr_stat = 1'b0;
    chk("clear wins err_cnt", 32'(err_cnt), 0);
    chk("clear ovf", 32'(ovf), 0);

    // Reset while waiting for idle
    out_ready = 1'b0;
    frame(8'h77, 1'b0);
    frame(8'h00, 1'b1); frame(8'h00, 1'b1); frame(8'h00, 1'b1);
    repeat (HOLD_CYC) step();
    chk("pre-reset state", 32'(state_o), 2);
    chk("pre-reset valid", 32'(out_valid), 1);
    ctl_rst = 1'b1;
    #1;
    chk("async reset rx_hold", 32'(rx_hold), 0);
    chk("async reset valid", 32'(out_valid), 0);
    chk("async reset state", 32'(state_o), 0);
    step();
    ctl_rst = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller placed directly behind the UART receiver (8 data bits, parity, 16x oversampling).
- Buffers error-free bytes in a small first-word-fall-through FIFO and counts parity/framing failures.
- After MAX_FAIL consecutive bad frames, holds the receiver in reset, then waits for an idle line before re-enabling it (resync).
- Presents a ready/valid byte stream and status counters to the host logic.

Parameters:
WIDTH, 8, data bits per frame (width of rx_byte and out_data)
DEPTH, 8, FIFO entries; power of 2, minimum 2
MAX_FAIL, 3, consecutive failed frames that trigger a resync; minimum 1
HOLD_CYC, 32, clock cycles rx_hold stays asserted in HOLD
IDLE_CYC, 160, consecutive line-high cycles required in WAIT_IDLE (10 bit times at 16x)

Ports:
ctl_clk  in  1  system clock (same clock as the receiver's oversampling clock)
ctl_rst  in  1  asynchronous reset, active-high
rx_byte  in  WIDTH  byte from the receiver, valid when rx_done=1
rx_done  in  1  one-cycle pulse at the end of each received frame
rx_fail  in  1  qualifies rx_done: 1 = parity or stop-bit error
rx_line  in  1  raw serial line, already synchronised; 1 = idle
rx_hold  out  1  1 = hold receiver in reset (top level inverts it into the receiver's active-low reset)
out_data  out  WIDTH  FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head when out_valid and out_ready are both 1
clr_stat  in  1  one-cycle pulse clearing err_cnt, resync_cnt and ovf
err_cnt  out  8  failed frames, saturates at 255
resync_cnt  out  4  completed resyncs, saturates at 15
ovf  out  1  sticky; set when a good byte is dropped because the FIFO is full
state_o  out  2  current state: 0=RUN, 1=HOLD, 2=WAIT_IDLE

Behaviour:
- Reset (async, ctl_rst=1):
  - State goes to RUN; FIFO empty; all counters 0.
  - Outputs: rx_hold=0, out_valid=0, out_data=0, ovf=0, err_cnt=0, resync_cnt=0.
- All other logic is synchronous to the rising edge of ctl_clk.
- FIFO (first-word-fall-through):
  - out_valid = (count != 0); out_data = head entry, registered storage.
  - Pop occurs when out_valid & out_ready.
  - Push: rx_done & !rx_fail in RUN. Accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle (count unchanged).
  - When full with no pop, the push is dropped and ovf is set.
  - Pop on an empty FIFO: no effect.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - A pushed byte is visible on out_data one cycle after rx_done (first-word latency 1).
- RUN state:
  - rx_done & !rx_fail: push the byte; fail_run cleared to 0.
  - rx_done & rx_fail: err_cnt increments (saturating); fail_run increments.
  - When fail_run reaches MAX_FAIL on this edge: go to HOLD, reload the hold counter, assert rx_hold on the next cycle.
  - rx_fail without rx_done is ignored.
- HOLD state:
  - rx_hold=1; rx_done is ignored.
  - After HOLD_CYC cycles, go to WAIT_IDLE.
- WAIT_IDLE state:
  - rx_hold=1; rx_done is ignored.
  - idle_cnt increments while rx_line=1 and clears to 0 when rx_line=0.
  - When idle_cnt reaches IDLE_CYC: go to RUN, rx_hold=0 on the next cycle, fail_run=0, resync_cnt increments (saturating).
- The FIFO remains poppable in every state; resync does not flush it.
- clr_stat: clears err_cnt, resync_cnt and ovf. Clear wins over a simultaneous increment or set. It does not affect state, FIFO or fail_run.
- Reset mid-resync: returns to RUN immediately, rx_hold=0, FIFO emptied.

Test Plan:
- Frames 0x34, 0xA8, 0xB4, all good, with out_ready=1 → out_data shows 0x34, 0xA8, 0xB4 in order, each with a one-cycle out_valid. err_cnt=0, state_o=0.
- Push 9 good bytes 0x01..0x09 with out_ready=0, DEPTH=8 → out_valid=1 throughout; 0x09 dropped and ovf=1. Raising out_ready then drains 0x01..0x08 in order.
- Push and pop in the same cycle while full → count stays 8 and the new byte lands at the tail; ovf stays 0.
- Fail, fail, good, fail → err_cnt=3, no resync (fail_run reset by the good frame), state_o=0.
- Three consecutive fails → rx_hold=1 the cycle after the third rx_done; after 32 cycles state_o=2.
  - Line held at 0 for 100 cycles, then 1 for 160 cycles → rx_hold=0 and resync_cnt=1.
  - An rx_done pulse injected during HOLD is not pushed and not counted.
- clr_stat pulsed on the same cycle as a failing rx_done with err_cnt=5 → err_cnt=0 and ovf=0. Separately, asserting ctl_rst during WAIT_IDLE → rx_hold=0 and out_valid=0 immediately.
